// File: rtl/bp_update_arbiter.sv
// Serialises up to two resolved branches per cycle onto the predictor's single
// update port, in program order, using a small circular FIFO for the overflow.
module bp_update_arbiter #(
    parameter int BPA_DEPTH       = 4,
    parameter int BPA_DEPTH_WIDTH = 2,
    localparam int XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            rob0_enable,
    input  logic [XLEN-1:0] rob0_inst_addr,
    input  logic            rob0_jump,
    input  logic            rob0_correct,
    input  logic            rob1_enable,
    input  logic [XLEN-1:0] rob1_inst_addr,
    input  logic            rob1_jump,
    input  logic            rob1_correct,
    output logic            bpa_full,
    output logic            bpa_enable,
    output logic [XLEN-1:0] bpa_inst_addr,
    output logic            bpa_jump,
    output logic            bpa_correct
);

    localparam int CW = BPA_DEPTH_WIDTH + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(BPA_DEPTH - 2);

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            jump;
        logic            correct;
    } entry_t;

    entry_t                     mem [BPA_DEPTH];
    logic [BPA_DEPTH_WIDTH-1:0] head;
    logic [BPA_DEPTH_WIDTH-1:0] tail;
    logic [CW-1:0]              count;

    entry_t     rob0_e;
    entry_t     rob1_e;
    entry_t     first_new;
    entry_t     push_a;
    entry_t     out_e;
    logic       take0;
    logic       take1;
    logic       pop;
    logic       out_valid;
    logic [1:0] n_new;
    logic [1:0] push_cnt;

    assign bpa_full = (count > FULL_LVL);

    // FIFO head always wins; otherwise the oldest new slot bypasses the FIFO
    // and only the younger one (if any) is queued.
    always_comb begin
        rob0_e    = '{addr: rob0_inst_addr, jump: rob0_jump, correct: rob0_correct};
        rob1_e    = '{addr: rob1_inst_addr, jump: rob1_jump, correct: rob1_correct};
        take0     = rob0_enable & ~bpa_full;
        take1     = rob1_enable & ~bpa_full;
        n_new     = {1'b0, take0} + {1'b0, take1};
        first_new = take0 ? rob0_e : rob1_e;
        pop       = (count != '0);
        out_e     = mem[head];
        out_valid = 1'b1;
        push_a    = first_new;
        push_cnt  = n_new;
        if (!pop) begin
            out_e     = first_new;
            out_valid = (n_new != 2'd0);
            push_a    = rob1_e;
            push_cnt  = (n_new == 2'd2) ? 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                bpa_enable    <= 1'b0;
                bpa_inst_addr <= '0;
                bpa_jump      <= 1'b0;
                bpa_correct   <= 1'b0;
            end else begin
                if (push_cnt != 2'd0)
                    mem[tail] <= push_a;
                if (push_cnt == 2'd2)
                    mem[tail + BPA_DEPTH_WIDTH'(1)] <= rob1_e;
                tail  <= tail + BPA_DEPTH_WIDTH'(push_cnt);
                head  <= head + BPA_DEPTH_WIDTH'(pop);
                count <= count + CW'(push_cnt) - CW'(pop);
                if (out_valid) begin
                    bpa_enable    <= 1'b1;
                    bpa_inst_addr <= out_e.addr;
                    bpa_jump      <= out_e.jump;
                    bpa_correct   <= out_e.correct;
                end else begin
                    bpa_enable    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Bench for bp_update_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_bp_update_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        rob0_enable, rob0_jump, rob0_correct;
    logic [31:0] rob0_inst_addr;
    logic        rob1_enable, rob1_jump, rob1_correct;
    logic [31:0] rob1_inst_addr;
    logic        bpa_full, bpa_enable, bpa_jump, bpa_correct;
    logic [31:0] bpa_inst_addr;

    bp_update_arbiter #(.BPA_DEPTH(DEPTH), .BPA_DEPTH_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rob0_enable(rob0_enable), .rob0_inst_addr(rob0_inst_addr),
        .rob0_jump(rob0_jump), .rob0_correct(rob0_correct),
        .rob1_enable(rob1_enable), .rob1_inst_addr(rob1_inst_addr),
        .rob1_jump(rob1_jump), .rob1_correct(rob1_correct),
        .bpa_full(bpa_full), .bpa_enable(bpa_enable),
        .bpa_inst_addr(bpa_inst_addr), .bpa_jump(bpa_jump), .bpa_correct(bpa_correct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        j;
        logic        c;
    } ent_t;

    ent_t        q[$];
    logic        m_en, m_j, m_c;
    logic [31:0] m_addr;
    int          errors = 0;
    int          checks = 0;
    int          upd_cnt = 0;
    logic        checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pending updates form one ordered list; the oldest goes out each edge.
    task automatic model_edge();
        ent_t e;
        if (!rdy) return;
        if (rst) begin
            q.delete();
            m_en = 1'b0; m_addr = '0; m_j = 1'b0; m_c = 1'b0;
            return;
        end
        if (!(q.size() > DEPTH - 2)) begin
            if (rob0_enable) q.push_back('{rob0_inst_addr, rob0_jump, rob0_correct});
            if (rob1_enable) q.push_back('{rob1_inst_addr, rob1_jump, rob1_correct});
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            m_en = 1'b1; m_addr = e.a; m_j = e.j; m_c = e.c;
        end else begin
            m_en = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("bpa_enable", 32'(bpa_enable), 32'(m_en));
            chk("bpa_full", 32'(bpa_full), 32'(q.size() > DEPTH - 2));
            chk("bpa_inst_addr", bpa_inst_addr, m_addr);
            chk("bpa_jump", 32'(bpa_jump), 32'(m_j));
            chk("bpa_correct", 32'(bpa_correct), 32'(m_c));
        end
    end

    task automatic step(input logic e0, input logic [31:0] a0, input logic j0, input logic c0,
                        input logic e1, input logic [31:0] a1, input logic j1, input logic c1,
                        input logic r, input logic y);
        rob0_enable = e0; rob0_inst_addr = a0; rob0_jump = j0; rob0_correct = c0;
        rob1_enable = e1; rob1_inst_addr = a1; rob1_jump = j1; rob1_correct = c1;
        rst = r; rdy = y;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (bpa_enable === 1'b1 && rdy) upd_cnt++;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic single(input logic [31:0] a, input logic j, input logic c);
        step(1'b1, a, j, c, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic dual(input logic [31:0] a0, input logic [31:0] a1);
        step(1'b1, a0, a0[2], ~a0[3], 1'b1, a1, a1[2], ~a1[3], 1'b0, 1'b1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            idle();
            if (!m_en && q.size() == 0 && bpa_enable === 1'b0) done = 1'b1;
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        checking = 1'b1;
        chk("reset_enable", 32'(bpa_enable), 32'd0);
        chk("reset_full", 32'(bpa_full), 32'd0);
        chk("reset_addr", bpa_inst_addr, 32'h0);

        // single bypass
        single(32'h1000, 1'b1, 1'b0);
        chk("bypass_en", 32'(bpa_enable), 32'd1);
        chk("bypass_addr", bpa_inst_addr, 32'h1000);
        chk("bypass_jump", 32'(bpa_jump), 32'd1);
        chk("bypass_corr", 32'(bpa_correct), 32'd0);
        idle();
        chk("bypass_after_en", 32'(bpa_enable), 32'd0);
        chk("bypass_after_addr", bpa_inst_addr, 32'h1000);

        // dual commit ordering
        dual(32'h2000, 32'h2004);
        chk("dual_first", bpa_inst_addr, 32'h2000);
        idle();
        chk("dual_second_en", 32'(bpa_enable), 32'd1);
        chk("dual_second", bpa_inst_addr, 32'h2004);
        idle();
        chk("dual_done_en", 32'(bpa_enable), 32'd0);

        // rob1 alone
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h5000, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rob1_only_addr", bpa_inst_addr, 32'h5000);
        chk("rob1_only_corr", 32'(bpa_correct), 32'd1);
        idle();

        // fill and back-pressure
        dual(32'h3000, 32'h3004);
        dual(32'h3008, 32'h300C);
        dual(32'h3010, 32'h3014);
        chk("fill_full", 32'(bpa_full), 32'd1);
        chk("fill_out3", bpa_inst_addr, 32'h3008);
        dual(32'h3018, 32'h301C);
        chk("fill_drop_out", bpa_inst_addr, 32'h300C);
        chk("fill_unfull", 32'(bpa_full), 32'd0);
        idle();
        chk("fill_drain1", bpa_inst_addr, 32'h3010);
        idle();
        chk("fill_drain2", bpa_inst_addr, 32'h3014);
        idle();
        chk("fill_dropped", 32'(bpa_enable), 32'd0);

        // wrap-around with a ROB that stalls on bpa_full
        upd_cnt = 0;
        begin
            int k = 0;
            int tries = 0;
            for (int i = 0; i < 10 && tries < 60; ) begin
                tries++;
                if (bpa_full) idle();
                else begin
                    if (i % 2 == 0) begin
                        single(32'h4000 + 32'(4 * k), k[0], k[1]);
                        k += 1;
                    end else begin
                        dual(32'h4000 + 32'(4 * k), 32'h4000 + 32'(4 * k + 4));
                        k += 2;
                    end
                    i++;
                end
            end
            chk("wrap_tries", 32'(tries < 60), 32'd1);
        end
        drain();
        chk("wrap_update_count", 32'(upd_cnt), 32'd15);

        // rdy stall with count=2
        dual(32'h7000, 32'h7004);
        dual(32'h7008, 32'h700C);
        chk("stall_pre_addr", bpa_inst_addr, 32'h7004);
        for (int i = 0; i < 5; i++) begin
            step(i[0], 32'h7F00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, (i == 2), 1'b0);
            chk("stall_hold_addr", bpa_inst_addr, 32'h7004);
            chk("stall_hold_en", 32'(bpa_enable), 32'd1);
        end
        idle();
        chk("stall_drain1", bpa_inst_addr, 32'h7008);
        idle();
        chk("stall_drain2", bpa_inst_addr, 32'h700C);
        idle();
        chk("stall_drained", 32'(bpa_enable), 32'd0);

        // reset mid-operation with count=3
        dual(32'h8000, 32'h8004);
        dual(32'h8008, 32'h800C);
        dual(32'h8010, 32'h8014);
        chk("rst_pre_full", 32'(bpa_full), 32'd1);
        step(1'b1, 32'h8F00, 1'b1, 1'b1, 1'b1, 32'h8F04, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_en", 32'(bpa_enable), 32'd0);
        chk("rst_full", 32'(bpa_full), 32'd0);
        chk("rst_addr", bpa_inst_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("rst_no_stale", 32'(bpa_enable), 32'd0);
        end
        single(32'h6000, 1'b0, 1'b1);
        chk("rst_after_addr", bpa_inst_addr, 32'h6000);
        idle();

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
